// File: rtl/core_preempt_arbiter.sv
// Preempting-resource arbiter: grants one decoder-slot request per cycle (oldest slot wins)
// and runs the LSU memory handshake. Define CORE_ARB_TIMEOUT_EN to enable the watchdog.
module core_preempt_arbiter #(
  parameter int N_SLOTS        = 4,
  parameter int AW             = 8,
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SLOTS-1:0]   req_lsu_en_i,
  input  logic [N_SLOTS-1:0]   req_lsu_wen_i,
  input  logic [N_SLOTS-1:0]   req_jump_en_i,
  input  logic [N_SLOTS-1:0]   req_halt_i,
  input  logic [N_SLOTS*AW-1:0] req_addr_i,
  input  logic [N_SLOTS*DW-1:0] req_wdata_i,
  input  logic [N_SLOTS*4-1:0] req_rd_i,
  output logic [N_SLOTS-1:0]   grant_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic                 wb_en_o,
  output logic [3:0]           wb_rd_o,
  output logic [DW-1:0]        wb_data_o,
  output logic                 jump_o,
  output logic [AW-1:0]        jump_pc_o,
  output logic                 halt_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;

  state_t        state;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [3:0]    lat_rd;
  logic          lat_we;

  logic               win_found;
  logic               win_halt;
  logic               win_jump;
  logic               win_we;
  logic [N_SLOTS-1:0] win_onehot;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;
  logic [3:0]         win_rd;
  logic               timeout_fire;

  // Lowest slot with any request wins; its own halt/jump/lsu bits decide the action.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    win_halt   = 1'b0;
    win_jump   = 1'b0;
    win_we     = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    win_rd     = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (!win_found && (req_lsu_en_i[k] || req_jump_en_i[k] || req_halt_i[k])) begin
        win_found     = 1'b1;
        win_onehot[k] = 1'b1;
        win_halt      = req_halt_i[k];
        win_jump      = req_jump_en_i[k];
        win_we        = req_lsu_wen_i[k];
        win_addr      = req_addr_i[k*AW +: AW];
        win_wdata     = req_wdata_i[k*DW +: DW];
        win_rd        = req_rd_i[k*4 +: 4];
      end
    end
  end

  assign grant_o     = (state == IDLE) ? win_onehot : '0;
  assign busy_o      = (state == REQ) || (state == WAIT);
  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = (state == REQ) && lat_we;
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;

`ifdef CORE_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] wd_cnt;

  // Counter restarts on every entry into REQ (from IDLE) and into WAIT (REQ + gnt).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (state == IDLE || (state == REQ && mem_gnt_i)) begin
      wd_cnt <= '0;
    end else if (busy_o) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign timeout_fire = (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) &&
                        ((state == REQ && !mem_gnt_i) || (state == WAIT && !mem_rvalid_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (timeout_fire) begin
      err_o <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= '0;
      lat_we    <= 1'b0;
      jump_o    <= 1'b0;
      jump_pc_o <= '0;
      wb_en_o   <= 1'b0;
      wb_rd_o   <= '0;
      wb_data_o <= '0;
      halt_o    <= 1'b0;
    end else begin
      jump_o  <= 1'b0;
      wb_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            if (win_halt) begin
              state  <= HALTED;
              halt_o <= 1'b1;
            end else if (win_jump) begin
              jump_o    <= 1'b1;
              jump_pc_o <= win_addr;
            end else begin
              lat_addr  <= win_addr;
              lat_wdata <= win_wdata;
              lat_rd    <= win_rd;
              lat_we    <= win_we;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            if (lat_we) begin
              state <= IDLE;
            end else if (mem_rvalid_i) begin
              // R0 is hardwired, so a load into it completes without a write strobe.
              wb_en_o   <= (lat_rd != 4'd0);
              wb_rd_o   <= lat_rd;
              wb_data_o <= mem_rdata_i;
              state     <= IDLE;
            end else begin
              state <= WAIT;
            end
          end else if (timeout_fire) begin
            state  <= HALTED;
            halt_o <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            wb_en_o   <= (lat_rd != 4'd0);
            wb_rd_o   <= lat_rd;
            wb_data_o <= mem_rdata_i;
            state     <= IDLE;
          end else if (timeout_fire) begin
            state  <= HALTED;
            halt_o <= 1'b1;
          end
        end
        HALTED: begin
          halt_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_preempt_arbiter.sv
// Self-checking bench for core_preempt_arbiter: directed test-plan cases plus randomized
// transactions whose expected timeline is derived from the arbitration rules.
module tb_core_preempt_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_lsu_en_i, req_lsu_wen_i, req_jump_en_i, req_halt_i;
  logic [31:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [15:0] req_rd_i;
  logic [3:0]  grant_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [15:0] mem_rdata_i;
  logic        wb_en_o;
  logic [3:0]  wb_rd_o;
  logic [15:0] wb_data_o;
  logic        jump_o;
  logic [7:0]  jump_pc_o;
  logic        halt_o, busy_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  core_preempt_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_lsu_en_i(req_lsu_en_i), .req_lsu_wen_i(req_lsu_wen_i),
    .req_jump_en_i(req_jump_en_i), .req_halt_i(req_halt_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .grant_o(grant_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .jump_o(jump_o), .jump_pc_o(jump_pc_o), .halt_o(halt_o), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] lsu, input logic [3:0] wen, input logic [3:0] jmp,
                               input logic [3:0] hlt, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [15:0] rd);
    req_lsu_en_i  = lsu;
    req_lsu_wen_i = wen;
    req_jump_en_i = jmp;
    req_halt_i    = hlt;
    req_addr_i    = addr;
    req_wdata_i   = wdata;
    req_rd_i      = rd;
  endtask

  task automatic clearInputs();
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 64'h0, 16'h0);
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 16'h0;
  endtask

  task automatic noiseRequests();
    applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom, {$urandom, $urandom}, 16'($urandom));
  endtask

  // One complete arbitration: grant cycle, then the action of the winning slot.
  // Timeline: store = grant, REQ x (gnt_dly+1), idle; load adds rv_dly WAIT cycles unless
  // the data comes with the grant; writeback strobe appears in the first idle cycle.
  task automatic runOp(input string tag, input logic [3:0] lsu, input logic [3:0] wen,
                       input logic [3:0] jmp, input logic [3:0] hlt, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [15:0] rd,
                       input int gnt_dly, input int rv_dly, input logic [15:0] rdata);
    int k;
    int kind;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [3:0]  r;
    logic        we;
    logic        same_cycle;
    k = -1;
    for (int i = 0; i < 4; i++)
      if (k < 0 && (lsu[i] || jmp[i] || hlt[i])) k = i;
    kind = hlt[k] ? 3 : (jmp[k] ? 2 : 1);
    a  = addr[k*8 +: 8];
    wd = wdata[k*16 +: 16];
    r  = rd[k*4 +: 4];
    we = wen[k];
    same_cycle = !we && (rv_dly == 0);

    applyStimulus(lsu, wen, jmp, hlt, addr, wdata, rd);
    mem_gnt_i    = 1'($urandom);
    mem_rvalid_i = 1'($urandom);
    mem_rdata_i  = 16'($urandom);
    #1;
    checkOutput({tag, ".grant"}, 32'(grant_o), 32'(4'b0001 << k));
    checkOutput({tag, ".idle_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, ".idle_memreq"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, ".idle_jump"}, 32'(jump_o), 32'd0);
    checkOutput({tag, ".idle_wb"}, 32'(wb_en_o), 32'd0);
    tick();
    clearInputs();

    if (kind == 3) begin
      #1;
      checkOutput({tag, ".halt"}, 32'(halt_o), 32'd1);
    end else if (kind == 2) begin
      #1;
      checkOutput({tag, ".jump"}, 32'(jump_o), 32'd1);
      checkOutput({tag, ".jump_pc"}, 32'(jump_pc_o), 32'(a));
      checkOutput({tag, ".jump_busy"}, 32'(busy_o), 32'd0);
      tick();
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        noiseRequests();
        mem_gnt_i    = (i == gnt_dly);
        mem_rvalid_i = (i == gnt_dly) ? same_cycle : 1'($urandom);
        mem_rdata_i  = (i == gnt_dly) ? rdata : 16'($urandom);
        #1;
        checkOutput({tag, ".req"}, 32'(mem_req_o), 32'd1);
        checkOutput({tag, ".we"}, 32'(mem_we_o), 32'(we));
        checkOutput({tag, ".addr"}, 32'(mem_addr_o), 32'(a));
        checkOutput({tag, ".wdata"}, 32'(mem_wdata_o), 32'(wd));
        checkOutput({tag, ".req_busy"}, 32'(busy_o), 32'd1);
        checkOutput({tag, ".req_grant"}, 32'(grant_o), 32'd0);
        tick();
      end
      if (!we && rv_dly > 0) begin
        for (int j = 1; j <= rv_dly; j++) begin
          noiseRequests();
          mem_gnt_i    = 1'($urandom);
          mem_rvalid_i = (j == rv_dly);
          mem_rdata_i  = (j == rv_dly) ? rdata : 16'($urandom);
          #1;
          checkOutput({tag, ".wait_busy"}, 32'(busy_o), 32'd1);
          checkOutput({tag, ".wait_memreq"}, 32'(mem_req_o), 32'd0);
          checkOutput({tag, ".wait_grant"}, 32'(grant_o), 32'd0);
          tick();
        end
      end
      clearInputs();
      #1;
      checkOutput({tag, ".done_busy"}, 32'(busy_o), 32'd0);
      checkOutput({tag, ".done_memreq"}, 32'(mem_req_o), 32'd0);
      checkOutput({tag, ".wb_en"}, 32'(wb_en_o), 32'(!we && r != 4'd0));
      if (!we && r != 4'd0) begin
        checkOutput({tag, ".wb_rd"}, 32'(wb_rd_o), 32'(r));
        checkOutput({tag, ".wb_data"}, 32'(wb_data_o), 32'(rdata));
      end
      tick();
    end
  endtask

  initial begin
    clearInputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("rst.grant", 32'(grant_o), 32'd0);
    checkOutput("rst.mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst.mem_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst.mem_addr", 32'(mem_addr_o), 32'd0);
    checkOutput("rst.mem_wdata", 32'(mem_wdata_o), 32'd0);
    checkOutput("rst.wb_en", 32'(wb_en_o), 32'd0);
    checkOutput("rst.wb_rd", 32'(wb_rd_o), 32'd0);
    checkOutput("rst.wb_data", 32'(wb_data_o), 32'd0);
    checkOutput("rst.jump", 32'(jump_o), 32'd0);
    checkOutput("rst.jump_pc", 32'(jump_pc_o), 32'd0);
    checkOutput("rst.halt", 32'(halt_o), 32'd0);
    checkOutput("rst.busy", 32'(busy_o), 32'd0);
    checkOutput("rst.err", 32'(err_o), 32'd0);
    tick();

    $display("[TB] load on slot 1");
    runOp("load", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'h0000_1200, 64'h0,
          16'h0030, 1, 2, 16'hBEEF);

    $display("[TB] oldest slot store beats younger jump");
    runOp("prio_store", 4'b0001, 4'b0001, 4'b0100, 4'b0000, 32'h0040_0005,
          64'h0000_0000_0000_1234, 16'h0, 0, 0, 16'h0);
    runOp("prio_jump", 4'b0000, 4'b0000, 4'b0100, 4'b0000, 32'h0040_0000, 64'h0,
          16'h0, 0, 0, 16'h0);

    $display("[TB] same-cycle gnt and rvalid into R0");
    runOp("r0_load", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0077, 64'h0,
          16'h0, 0, 0, 16'h5555);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      logic [3:0] lsu, jmp;
      lsu = 4'($urandom);
      jmp = 4'($urandom) & 4'($urandom);
      if ((lsu | jmp) == 4'h0) lsu = 4'b0001 << $urandom_range(0, 3);
      runOp("rand", lsu, 4'($urandom), jmp, 4'h0, $urandom, {$urandom, $urandom},
            16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
    end

    $display("[TB] reset while waiting for read data");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0033, 64'h0, 16'h0005);
    #1;
    checkOutput("wrst.grant", 32'(grant_o), 32'd1);
    tick();
    clearInputs();
    mem_gnt_i = 1'b1;
    #1;
    checkOutput("wrst.req", 32'(mem_req_o), 32'd1);
    tick();
    mem_gnt_i = 1'b0;
    rst_i     = 1'b1;
    #1;
    checkOutput("wrst.wait_busy", 32'(busy_o), 32'd1);
    tick();
    rst_i        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 16'hAAAA;
    #1;
    checkOutput("wrst.memreq", 32'(mem_req_o), 32'd0);
    checkOutput("wrst.busy", 32'(busy_o), 32'd0);
    checkOutput("wrst.wb_en", 32'(wb_en_o), 32'd0);
    tick();
    clearInputs();
    #1;
    checkOutput("wrst.late_wb", 32'(wb_en_o), 32'd0);
    checkOutput("wrst.late_busy", 32'(busy_o), 32'd0);
    tick();

    $display("[TB] halt beats jump on slot 3");
    runOp("halt", 4'b0000, 4'b0000, 4'b1000, 4'b1000, 32'h5500_0000, 64'h0,
          16'h0, 0, 0, 16'h0);
    tick();
    for (int n = 0; n < 4; n++) begin
      noiseRequests();
      mem_gnt_i = 1'($urandom);
      #1;
      checkOutput("halted.grant", 32'(grant_o), 32'd0);
      checkOutput("halted.halt", 32'(halt_o), 32'd1);
      checkOutput("halted.memreq", 32'(mem_req_o), 32'd0);
      checkOutput("halted.jump", 32'(jump_o), 32'd0);
      tick();
    end
    clearInputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checkOutput("halted.rst_halt", 32'(halt_o), 32'd0);
    checkOutput("halted.rst_busy", 32'(busy_o), 32'd0);
    tick();
    runOp("post_halt", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 32'h0099_0000,
          64'h0000_CAFE_0000_0000, 16'h0, 1, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
